paddle_sm: RTL
==============

PADDLE_SM -- requirements
Module: paddle_sm

Interface
REQ-001 Parameter DEB_CYCLES, 4, consecutive stable synchronized samples required to accept a new button level.
REQ-002 Parameter MOVE_DIV, 8, sys_clk cycles per movement tick.
REQ-003 Parameter STEP, 4, paddle displacement per tick, in pixels.
REQ-004 Parameter POS_MIN, 50, lowest allowed paddle centre; POS_MAX, 430, highest; POS_RESET, 245, reset/serve centre.
REQ-005 Parameter CPU_DEAD, 8, dead-band in pixels for CPU-driven paddle 2.
REQ-006 Port list, one per line:
- sys_clk  in  1  clock; reset synchronous, active-high, sampled on sys_clk.
- reset  in  1  synchronous active-high reset.
- p1_up, p1_down, p2_up, p2_down  in  1 each  raw asynchronous button levels, active-high.
- cpu_mode  in  1  1 = paddle 2 driven by ball tracking; p2 buttons ignored.
- ball_y  in  10  current ball centre row from the ball engine.
- game_over  in  1  freezes both paddles while high.
- p1_position, p2_position  out  10  paddle centre rows consumed by the ball engine and video.
- p1_moving, p2_moving  out  1  high while the paddle FSM is in UP or DOWN.

Function
REQ-007 Each raw button shall pass through a 2-flop synchronizer before use.
REQ-008 The debounced level shall change only after the synchronized level has differed from it for DEB_CYCLES consecutive cycles; any mismatch-free cycle restarts the count.
REQ-009 A free-running tick counter 0..MOVE_DIV-1 shall pulse tick for one cycle when the count equals MOVE_DIV-1, then wrap to 0.
REQ-010 Command per paddle: UP_CMD = up & ~down, DN_CMD = down & ~up; both or neither = no command.
REQ-011 For paddle 2 with cpu_mode=1: UP_CMD when ball_y + CPU_DEAD < p2_position; DN_CMD when ball_y > p2_position + CPU_DEAD; otherwise no command; 11-bit compare, no wrap.
REQ-012 Each paddle has its own FSM with states IDLE, UP, DOWN, HOLD, registered one cycle after the command.
REQ-013 Transitions: game_over=1 -> HOLD from any state; HOLD & game_over=0 -> IDLE; else UP_CMD -> UP, DN_CMD -> DOWN, none -> IDLE.
REQ-014 On a tick cycle in UP: position <= POS_MIN if position < POS_MIN+STEP, else position-STEP; UP means decreasing row.
REQ-015 On a tick cycle in DOWN: position <= POS_MAX if position > POS_MAX-STEP, else position+STEP.
REQ-016 Position shall not change in IDLE or HOLD, or on non-tick cycles.
REQ-017 Position shall always lie in [POS_MIN, POS_MAX]; no underflow or overflow on any path.
REQ-018 A change of cpu_mode mid-movement takes effect on the next command evaluation, with no position jump.
REQ-019 pN_moving shall be registered state decode: 1 in UP/DOWN, 0 in IDLE/HOLD.

Reset
REQ-020 While reset=1: positions = POS_RESET, both FSMs = IDLE, moving = 0, tick counter = 0, debounce counters = 0, debounced levels = 0, synchronizers = 0.
REQ-021 Reset asserted mid-move shall return positions to POS_RESET on the first clock edge with reset high, regardless of game_over.

Verification
REQ-022 Hold p1_up high for 500 cycles -> p1_position steps 245, 241, 237, ... one step per 8 cycles, reaches 53, then holds at 50; p1_moving=1 throughout.
REQ-023 Pulse p1_down high for 2 cycles only -> no debounced change, p1_position stays 245, p1_moving stays 0.
REQ-024 Hold p2_up and p2_down both high with cpu_mode=0 -> p2 FSM stays IDLE, p2_position stays 245.
REQ-025 cpu_mode=1, ball_y=400 held -> p2_position rises by 4 per tick to 393 and stops; p2_moving drops to 0.
REQ-026 p1_down held, game_over asserted at p1_position=265 -> position frozen at 265 while game_over=1; movement resumes after game_over deasserts.
REQ-027 reset pulsed during an active move -> both positions read 245 and moving=0 the cycle after the reset edge.

Source files
------------

// File: rtl/paddle_sm.sv
// Two-player paddle controller: synchronised, debounced buttons (or ball tracking for
// paddle 2) drive per-paddle FSMs that step the paddle centre once per movement tick.
module paddle_sm #(
  parameter int DEB_CYCLES = 4,
  parameter int MOVE_DIV   = 8,
  parameter int STEP       = 4,
  parameter int POS_MIN    = 50,
  parameter int POS_MAX    = 430,
  parameter int POS_RESET  = 245,
  parameter int CPU_DEAD   = 8
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       p1_up,
  input  logic       p1_down,
  input  logic       p2_up,
  input  logic       p2_down,
  input  logic       cpu_mode,
  input  logic [9:0] ball_y,
  input  logic       game_over,
  output logic [9:0] p1_position,
  output logic [9:0] p2_position,
  output logic       p1_moving,
  output logic       p2_moving
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int TW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

  localparam logic [10:0] MIN_W  = 11'(POS_MIN);
  localparam logic [10:0] MAX_W  = 11'(POS_MAX);
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [10:0] DEAD_W = 11'(CPU_DEAD);

  typedef enum logic [1:0] {IDLE, UP, DOWN, HOLD} state_e;

  // Button order: {p2_down, p2_up, p1_down, p1_up}
  logic [3:0]    raw;
  logic [3:0]    sync1_q, sync2_q, deb_q;
  logic [CW-1:0] cnt_q [4];
  logic [TW-1:0] tick_cnt_q;
  logic          tick;
  logic [1:0]    up_cmd, dn_cmd, mov_q;
  state_e        st_q [2];
  state_e        st_d [2];
  logic [9:0]    pos_q [2];
  logic [9:0]    pos_d [2];

  assign raw  = {p2_down, p2_up, p1_down, p1_up};
  assign tick = (tick_cnt_q == TW'(MOVE_DIV - 1));

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] != deb_q[i]) begin
          if (cnt_q[i] == CW'(DEB_CYCLES - 1)) begin
            deb_q[i] <= sync2_q[i];
            cnt_q[i] <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) tick_cnt_q <= '0;
    else if (tick) tick_cnt_q <= '0;
    else tick_cnt_q <= tick_cnt_q + 1'b1;
  end

  // Paddle 2 in CPU mode chases the ball with a dead-band; widened to avoid wrap.
  always_comb begin
    up_cmd    = '0;
    dn_cmd    = '0;
    up_cmd[0] = deb_q[0] & ~deb_q[1];
    dn_cmd[0] = deb_q[1] & ~deb_q[0];
    if (cpu_mode) begin
      up_cmd[1] = ({1'b0, ball_y} + DEAD_W) < {1'b0, pos_q[1]};
      dn_cmd[1] = {1'b0, ball_y} > ({1'b0, pos_q[1]} + DEAD_W);
    end else begin
      up_cmd[1] = deb_q[2] & ~deb_q[3];
      dn_cmd[1] = deb_q[3] & ~deb_q[2];
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      st_d[i]  = IDLE;
      pos_d[i] = pos_q[i];
      if (game_over)            st_d[i] = HOLD;
      else if (st_q[i] == HOLD) st_d[i] = IDLE;
      else if (up_cmd[i])       st_d[i] = UP;
      else if (dn_cmd[i])       st_d[i] = DOWN;
      if (tick && st_q[i] == UP) begin
        if ({1'b0, pos_q[i]} < MIN_W + STEP_W) pos_d[i] = MIN_W[9:0];
        else                                   pos_d[i] = pos_q[i] - STEP_W[9:0];
      end else if (tick && st_q[i] == DOWN) begin
        if ({1'b0, pos_q[i]} > MAX_W - STEP_W) pos_d[i] = MAX_W[9:0];
        else                                   pos_d[i] = pos_q[i] + STEP_W[9:0];
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        st_q[i]  <= IDLE;
        pos_q[i] <= 10'(POS_RESET);
        mov_q[i] <= 1'b0;
      end else begin
        st_q[i]  <= st_d[i];
        pos_q[i] <= pos_d[i];
        mov_q[i] <= (st_d[i] == UP) || (st_d[i] == DOWN);
      end
    end
  end

  assign p1_position = pos_q[0];
  assign p2_position = pos_q[1];
  assign p1_moving   = mov_q[0];
  assign p2_moving   = mov_q[1];

endmodule
